// File: rtl/riscv_dmem_arb.sv
// Round-robin arbiter between the load/store unit (m0) and a DMA/debug loader (m1) sharing one
// single-port data memory; handles byte lanes, alignment checks and load extension.
module riscv_dmem_arb #(
    parameter int XLEN          = 32,
    parameter int DMEM_ADDR_BIT = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_m0_req,
    input  logic                     i_m0_we,
    input  logic [DMEM_ADDR_BIT-1:0] i_m0_addr,
    input  logic [1:0]               i_m0_size,
    input  logic                     i_m0_sext,
    input  logic [XLEN-1:0]          i_m0_wdata,
    output logic                     o_m0_gnt,
    output logic                     o_m0_rvalid,
    output logic [XLEN-1:0]          o_m0_rdata,
    output logic                     o_m0_err,
    input  logic                     i_m1_req,
    input  logic                     i_m1_we,
    input  logic [DMEM_ADDR_BIT-1:0] i_m1_addr,
    input  logic [1:0]               i_m1_size,
    input  logic                     i_m1_sext,
    input  logic [XLEN-1:0]          i_m1_wdata,
    output logic                     o_m1_gnt,
    output logic                     o_m1_rvalid,
    output logic [XLEN-1:0]          o_m1_rdata,
    output logic                     o_m1_err,
    output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
    output logic [XLEN-1:0]          o_dmem_data,
    output logic [XLEN/8-1:0]        o_dmem_byte_sel,
    output logic                     o_dmem_wr_en,
    input  logic [XLEN-1:0]          i_dmem_data
);

    // last_reg = 1 means m1 was granted most recently, so m0 wins the next tie
    logic                     last_reg;
    logic [1:0]               gnt;
    logic                     any_gnt;
    logic                     sel_we;
    logic [DMEM_ADDR_BIT-1:0] sel_addr;
    logic [1:0]               sel_size;
    logic                     sel_sext;
    logic [XLEN-1:0]          sel_wdata;
    logic [1:0]               offset;
    logic                     bad_access;
    logic                     mem_active;
    logic [XLEN-1:0]          shifted;
    logic [XLEN-1:0]          resp_data;

    assign gnt[0]   = i_m0_req & (~i_m1_req | last_reg);
    assign gnt[1]   = i_m1_req & (~i_m0_req | ~last_reg);
    assign any_gnt  = |gnt;
    assign o_m0_gnt = gnt[0];
    assign o_m1_gnt = gnt[1];

    always_comb begin
        sel_we    = gnt[1] ? i_m1_we    : i_m0_we;
        sel_addr  = gnt[1] ? i_m1_addr  : i_m0_addr;
        sel_size  = gnt[1] ? i_m1_size  : i_m0_size;
        sel_sext  = gnt[1] ? i_m1_sext  : i_m0_sext;
        sel_wdata = gnt[1] ? i_m1_wdata : i_m0_wdata;
        offset    = sel_addr[1:0];
        case (sel_size)
            2'd0:    bad_access = 1'b0;
            2'd1:    bad_access = offset[0];
            2'd2:    bad_access = (offset != 2'd0);
            default: bad_access = 1'b1;
        endcase
        mem_active = any_gnt & ~bad_access;
    end

    // Memory side: everything stays at zero unless a well-formed access is granted
    always_comb begin
        o_dmem_addr     = '0;
        o_dmem_data     = '0;
        o_dmem_byte_sel = '0;
        o_dmem_wr_en    = 1'b0;
        if (mem_active) begin
            o_dmem_addr  = sel_addr[DMEM_ADDR_BIT-1:2];
            o_dmem_wr_en = sel_we;
            case (sel_size)
                2'd0: begin
                    o_dmem_byte_sel = (XLEN/8)'(1) << offset;
                    o_dmem_data     = {(XLEN/8){sel_wdata[7:0]}};
                end
                2'd1: begin
                    o_dmem_byte_sel = (XLEN/8)'(3) << offset;
                    o_dmem_data     = {(XLEN/16){sel_wdata[15:0]}};
                end
                default: begin
                    o_dmem_byte_sel = '1;
                    o_dmem_data     = sel_wdata;
                end
            endcase
        end
    end

    always_comb begin
        shifted   = i_dmem_data >> {offset, 3'b000};
        resp_data = '0;
        if (mem_active && !sel_we) begin
            case (sel_size)
                2'd0:    resp_data = {{(XLEN-8){sel_sext & shifted[7]}}, shifted[7:0]};
                2'd1:    resp_data = {{(XLEN-16){sel_sext & shifted[15]}}, shifted[15:0]};
                default: resp_data = shifted;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            last_reg <= 1'b1;
        end else if (any_gnt) begin
            last_reg <= gnt[1];
        end
    end

    logic [1:0]      rvalid_reg;
    logic [1:0]      err_reg;
    logic [XLEN-1:0] rdata_reg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    rvalid_reg[gi] <= 1'b0;
                    err_reg[gi]    <= 1'b0;
                    rdata_reg[gi]  <= '0;
                end else begin
                    rvalid_reg[gi] <= gnt[gi];
                    err_reg[gi]    <= gnt[gi] & bad_access;
                    rdata_reg[gi]  <= gnt[gi] ? resp_data : '0;
                end
            end
        end
    endgenerate

    assign o_m0_rvalid = rvalid_reg[0];
    assign o_m0_err    = err_reg[0];
    assign o_m0_rdata  = rdata_reg[0];
    assign o_m1_rvalid = rvalid_reg[1];
    assign o_m1_err    = err_reg[1];
    assign o_m1_rdata  = rdata_reg[1];

endmodule

// File: tb/tb_riscv_dmem_arb.sv
// Directed self-checking bench for riscv_dmem_arb with a behavioural byte-lane data memory.
module tb_riscv_dmem_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_req, m0_we, m0_sext, m1_req, m1_we, m1_sext;
    logic [11:0] m0_addr, m1_addr;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_byte_sel;
    logic        dmem_wr_en;

    logic [31:0] mem [0:1023];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign dmem_rdata = mem[dmem_addr];
    always @(posedge clk) begin
        if (dmem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (dmem_byte_sel[b]) mem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
    end

    riscv_dmem_arb #(.XLEN(32), .DMEM_ADDR_BIT(12)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_size(m0_size),
        .i_m0_sext(m0_sext), .i_m0_wdata(m0_wdata),
        .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata), .o_m0_err(m0_err),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_size(m1_size),
        .i_m1_sext(m1_sext), .i_m1_wdata(m1_wdata),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata), .o_m1_err(m1_err),
        .o_dmem_addr(dmem_addr), .o_dmem_data(dmem_wdata), .o_dmem_byte_sel(dmem_byte_sel),
        .o_dmem_wr_en(dmem_wr_en), .i_dmem_data(dmem_rdata)
    );

    task automatic drive0(input logic req, input logic we, input logic [11:0] addr,
                          input logic [1:0] size, input logic sext, input logic [31:0] wdata);
        m0_req = req; m0_we = we; m0_addr = addr; m0_size = size; m0_sext = sext; m0_wdata = wdata;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [11:0] addr,
                          input logic [1:0] size, input logic sext, input logic [31:0] wdata);
        m1_req = req; m1_we = we; m1_addr = addr; m1_size = size; m1_sext = sext; m1_wdata = wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive0(0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({m0_rvalid, m0_err, m1_rvalid, m1_err} !== 4'b0 || m0_rdata !== 0 || m1_rdata !== 0) begin
            fails++;
            $display("FAIL reset_resp: rv/err=%b rdata0=%h rdata1=%h required all 0",
                     {m0_rvalid, m0_err, m1_rvalid, m1_err}, m0_rdata, m1_rdata);
        end
        tests++;
        if (dmem_wr_en !== 0 || dmem_byte_sel !== 0 || dmem_addr !== 0 || dmem_wdata !== 0) begin
            fails++;
            $display("FAIL reset_idle: we=%b bs=%b addr=%h data=%h required all 0",
                     dmem_wr_en, dmem_byte_sel, dmem_addr, dmem_wdata);
        end
        @(negedge clk);
        rstn = 1'b1;
        next_cycle();
        $display("[TB] test_reset done");
    endtask

    task automatic test_first_tie();
        mem[4] = 32'h11223344;
        drive0(1, 0, 12'h010, 2, 0, 0);
        drive1(1, 0, 12'h010, 2, 0, 0);
        #1;
        tests++;
        if (m0_gnt !== 1 || m1_gnt !== 0) begin
            fails++;
            $display("FAIL tie_cycle0: gnt0=%b gnt1=%b required 1 0", m0_gnt, m1_gnt);
        end
        next_cycle();
        m0_req = 0;
        #1;
        tests++;
        if (m0_gnt !== 0 || m1_gnt !== 1) begin
            fails++;
            $display("FAIL tie_cycle1: gnt0=%b gnt1=%b required 0 1", m0_gnt, m1_gnt);
        end
        tests++;
        if (m0_rvalid !== 1 || m1_rvalid !== 0 || m0_rdata !== 32'h11223344) begin
            fails++;
            $display("FAIL tie_rsp0: rv0=%b rv1=%b rdata0=%h required 1 0 11223344",
                     m0_rvalid, m1_rvalid, m0_rdata);
        end
        next_cycle();
        m1_req = 0;
        tests++;
        if (m1_rvalid !== 1 || m0_rvalid !== 0 || m1_rdata !== 32'h11223344) begin
            fails++;
            $display("FAIL tie_rsp1: rv1=%b rv0=%b rdata1=%h required 1 0 11223344",
                     m1_rvalid, m0_rvalid, m1_rdata);
        end
        next_cycle();
        $display("[TB] test_first_tie done");
    endtask

    task automatic test_byte_half_store();
        mem[8] = 32'h0;
        drive0(1, 1, 12'h021, 0, 0, 32'h000000AB);
        #1;
        tests++;
        if (dmem_byte_sel !== 4'b0010 || dmem_wr_en !== 1 || dmem_wdata !== 32'hABABABAB || dmem_addr !== 10'd8) begin
            fails++;
            $display("FAIL store_byte: bs=%b we=%b data=%h addr=%h required 0010 1 ababab 8",
                     dmem_byte_sel, dmem_wr_en, dmem_wdata, dmem_addr);
        end
        next_cycle();
        drive0(1, 1, 12'h022, 1, 0, 32'h0000BEEF);
        #1;
        tests++;
        if (dmem_byte_sel !== 4'b1100 || dmem_wdata !== 32'hBEEFBEEF) begin
            fails++;
            $display("FAIL store_half: bs=%b data=%h required 1100 beefbeef", dmem_byte_sel, dmem_wdata);
        end
        tests++;
        if (m0_rvalid !== 1 || m0_rdata !== 0 || m0_err !== 0) begin
            fails++;
            $display("FAIL store_rsp: rv=%b rdata=%h err=%b required 1 0 0", m0_rvalid, m0_rdata, m0_err);
        end
        next_cycle();
        drive0(1, 0, 12'h020, 2, 0, 0);
        next_cycle();
        m0_req = 0;
        tests++;
        if (m0_rvalid !== 1 || m0_rdata !== 32'hBEEFAB00) begin
            fails++;
            $display("FAIL store_readback: rv=%b rdata=%h required 1 beefab00", m0_rvalid, m0_rdata);
        end
        next_cycle();
        $display("[TB] test_byte_half_store done");
    endtask

    task automatic test_load_ext();
        logic [11:0] addrs [4]  = '{12'h023, 12'h023, 12'h020, 12'h022};
        logic [1:0]  sizes [4]  = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        sexts [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] expect_d [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'hFFFF80FF};
        mem[8] = 32'h80FF7F01;
        for (int i = 0; i < 4; i++) begin
            drive1(1, 0, addrs[i], sizes[i], sexts[i], 0);
            next_cycle();
            m1_req = 0;
            tests++;
            if (m1_rvalid !== 1 || m1_err !== 0 || m1_rdata !== expect_d[i]) begin
                fails++;
                $display("FAIL load_ext%0d: rv=%b err=%b rdata=%h required 1 0 %h",
                         i, m1_rvalid, m1_err, m1_rdata, expect_d[i]);
            end
            $display("[TB] load addr=%h size=%0d sext=%b rdata=%h", addrs[i], sizes[i], sexts[i], m1_rdata);
        end
        next_cycle();
    endtask

    task automatic test_misalign();
        drive0(1, 0, 12'h022, 2, 0, 0);
        #1;
        tests++;
        if (m0_gnt !== 1 || dmem_wr_en !== 0 || dmem_byte_sel !== 0) begin
            fails++;
            $display("FAIL mis_load_req: gnt=%b we=%b bs=%b required 1 0 0000", m0_gnt, dmem_wr_en, dmem_byte_sel);
        end
        next_cycle();
        m0_req = 0;
        tests++;
        if (m0_rvalid !== 1 || m0_err !== 1 || m0_rdata !== 0) begin
            fails++;
            $display("FAIL mis_load_rsp: rv=%b err=%b rdata=%h required 1 1 0", m0_rvalid, m0_err, m0_rdata);
        end
        drive1(1, 1, 12'h013, 1, 0, 32'h00005555);
        #1;
        tests++;
        if (m1_gnt !== 1 || dmem_wr_en !== 0 || dmem_byte_sel !== 0) begin
            fails++;
            $display("FAIL mis_store_req: gnt=%b we=%b bs=%b required 1 0 0000", m1_gnt, dmem_wr_en, dmem_byte_sel);
        end
        next_cycle();
        m1_req = 0;
        tests++;
        if (m1_rvalid !== 1 || m1_err !== 1 || m1_rdata !== 0 || m0_rvalid !== 0) begin
            fails++;
            $display("FAIL mis_store_rsp: rv1=%b err=%b rdata=%h rv0=%b required 1 1 0 0",
                     m1_rvalid, m1_err, m1_rdata, m0_rvalid);
        end
        tests++;
        if (mem[4] !== 32'h11223344 || mem[8] !== 32'h80FF7F01) begin
            fails++;
            $display("FAIL mis_mem: w4=%h w8=%h required 11223344 80ff7f01", mem[4], mem[8]);
        end
        next_cycle();
        $display("[TB] test_misalign done");
    endtask

    task automatic test_fairness();
        int g0 = 0;
        int g1 = 0;
        drive0(1, 0, 12'h020, 2, 0, 0);
        drive1(1, 0, 12'h010, 2, 0, 0);
        #1;
        for (int i = 0; i < 10; i++) begin
            g0 += int'(m0_gnt);
            g1 += int'(m1_gnt);
            tests++;
            if (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1)) begin
                fails++;
                $display("FAIL fair_gnt%0d: gnt0=%b gnt1=%b required %b %b",
                         i, m0_gnt, m1_gnt, i % 2 == 0, i % 2 == 1);
            end
            if (i > 0) begin
                tests++;
                if (m0_rvalid !== (i % 2 == 1) || m1_rvalid !== (i % 2 == 0) ||
                    (m0_rvalid === 1 && m0_rdata !== 32'h80FF7F01) ||
                    (m1_rvalid === 1 && m1_rdata !== 32'h11223344)) begin
                    fails++;
                    $display("FAIL fair_rv%0d: rv0=%b rv1=%b rdata0=%h rdata1=%h required %b %b",
                             i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, i % 2 == 1, i % 2 == 0);
                end
            end
            next_cycle();
        end
        m0_req = 0;
        m1_req = 0;
        tests++;
        if (m1_rvalid !== 1 || m0_rvalid !== 0 || g0 != 5 || g1 != 5) begin
            fails++;
            $display("FAIL fair_total: rv1=%b rv0=%b g0=%0d g1=%0d required 1 0 5 5", m1_rvalid, m0_rvalid, g0, g1);
        end
        next_cycle();
        $display("[TB] test_fairness grants m0=%0d m1=%0d", g0, g1);
    endtask

    task automatic test_reset_mid_load();
        drive1(1, 0, 12'h010, 2, 0, 0);
        #1;
        tests++;
        if (m1_gnt !== 1) begin
            fails++;
            $display("FAIL rst_mid_gnt: gnt1=%b required 1", m1_gnt);
        end
        @(posedge clk);
        rstn = 1'b0;
        m1_req = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if ({m0_rvalid, m0_err, m1_rvalid, m1_err} !== 4'b0 || m0_rdata !== 0 || m1_rdata !== 0) begin
                fails++;
                $display("FAIL rst_mid_resp%0d: rv/err=%b rdata0=%h rdata1=%h required all 0",
                         i, {m0_rvalid, m0_err, m1_rvalid, m1_err}, m0_rdata, m1_rdata);
            end
            @(posedge clk);
        end
        @(negedge clk);
        rstn = 1'b1;
        next_cycle();
        drive0(1, 0, 12'h010, 2, 0, 0);
        drive1(1, 0, 12'h010, 2, 0, 0);
        #1;
        tests++;
        if (m0_gnt !== 1 || m1_gnt !== 0) begin
            fails++;
            $display("FAIL rst_mid_tie: gnt0=%b gnt1=%b required 1 0", m0_gnt, m1_gnt);
        end
        m0_req = 0;
        m1_req = 0;
        next_cycle();
        $display("[TB] test_reset_mid_load done");
    endtask

    initial begin
        test_reset();
        test_first_tie();
        test_byte_half_store();
        test_load_ext();
        test_misalign();
        test_fairness();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_dmem_arb.md
# riscv_dmem_arb

Two-port arbiter and access sequencer in front of the single-port data memory `riscv_dmem`. It shares the memory between the core load/store unit (master 0) and a DMA/debug loader (master 1) using round-robin arbitration. It converts byte-addressed, sized requests into word address, byte-lane select and lane-replicated write data. Read data comes back registered, lane-aligned and sign- or zero-extended.

## Interface
- `XLEN`, default 32: data width; only 32 is supported.
- `DMEM_ADDR_BIT`, default 12: byte-address width of data memory.
- `i_clk` in 1: clock, rising edge.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_mN_req` in 1 (N=0,1): access request, held until granted.
- `i_mN_we` in 1: 1 = store, 0 = load.
- `i_mN_addr` in DMEM_ADDR_BIT: byte address.
- `i_mN_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `i_mN_sext` in 1: sign-extend load result.
- `i_mN_wdata` in XLEN: store data, right-justified.
- `o_mN_gnt` out 1: request accepted this cycle (combinational).
- `o_mN_rvalid` out 1: one-cycle completion pulse.
- `o_mN_rdata` out XLEN: load result, valid with rvalid.
- `o_mN_err` out 1: misaligned/illegal access, valid with rvalid.
- `o_dmem_addr` out DMEM_ADDR_BIT-2: word address to memory.
- `o_dmem_data` out XLEN: lane-replicated write data.
- `o_dmem_byte_sel` out XLEN/8: byte enables.
- `o_dmem_wr_en` out 1: memory write enable.
- `i_dmem_data` in XLEN: memory read word (combinational read).

## Operation
- **Arbitration:** a one-bit pointer `last` records the most recently granted master.
  - One requester asserts req: it is granted.
  - Both assert req: the master other than `last` is granted.
  - At most one gnt is high per cycle.
  - `last` updates on every accepted request (req & gnt).
- **Acceptance:** an access is accepted on the rising edge where req & gnt. The requester may change its fields in the next cycle. No back-pressure on responses; a master may issue a new request while its previous rvalid is in flight.
- **Alignment check:** the access is misaligned if size=1 with addr[0]=1, or size=2 with addr[1:0]≠0. size=3 is illegal. A misaligned or illegal access is still granted, but the memory side stays idle (wr_en=0, byte_sel=0). The response carries err=1 and rdata=0.
- **Byte enables:**
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
- **Write data:**
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- **Memory address:** o_dmem_addr = addr[DMEM_ADDR_BIT-1:2] of the granted master.
- **Store:** o_dmem_wr_en = granted & we & aligned. The memory writes on the same edge.
- **Load:** i_dmem_data is sampled at the acceptance edge. It is shifted right by 8·addr[1:0], then truncated to 8/16/32 bits. Bits above are filled with the MSB of the truncated field if sext=1, else with 0.
- **Idle cycle (no gnt):** o_dmem_wr_en=0, o_dmem_byte_sel=0, o_dmem_addr=0, o_dmem_data=0.

## Timing
- Grant: 0 cycles (combinational from req, `last`, size, addr).
- Response: o_mN_rvalid is high exactly one cycle after acceptance, for one cycle, for loads and stores alike. A store's rdata=0.
- Throughput: one access per cycle total. A lone master can be accepted every cycle. Under contention, each master is accepted every second cycle.
- **Reset values:**
  - `last`=1, so master 0 wins the first tie.
  - o_mN_rvalid=0, o_mN_rdata=0, o_mN_err=0.
  - Combinational outputs follow the idle rule while req is low.
- **Reset mid-operation:** asserting i_rstn low clears rvalid, rdata, err and `last` immediately.
  - A load accepted on the edge before reset produces no response.
  - A store accepted before reset is already committed in memory.
- **Simultaneous requests to the same word:** the order is determined by `last`. A load granted in the cycle after a store sees the stored data.
- **Responses:** rvalid of m0 and m1 never coincide.

## Test plan
- **Reset and first tie:** release reset, then both masters load word at 0x10 in the same cycle. Required: o_m0_gnt=1 and o_m1_gnt=0 in cycle 0. m1 is granted in cycle 1. The rvalids follow in cycles 1 and 2.
- **Byte/half stores:** m0 stores 0xAB at 0x21, then 0xBEEF at 0x22, to word previously 0x00000000. Required: byte_sel is 4'b0010, then 4'b1100. A word load of 0x20 returns 0xBEEFAB00.
- **Load extension:** memory word 0x20 holds 0x80FF7F01.
  - Byte load at 0x23 with sext=1 returns 0xFFFFFF80; with sext=0 it returns 0x00000080.
  - Half load at 0x20 with sext=1 returns 0x00007F01.
- **Misalignment:** word load at 0x22, and half store at 0x13.
  - Required: gnt=1, wr_en=0, byte_sel=0.
  - Next cycle: rvalid=1, err=1, rdata=0.
  - Memory contents are unchanged.
- **Fairness:** both masters hold req high for 10 cycles with back-to-back word loads. Required: grants alternate m0, m1, m0, …, each master gets 5 grants, and rvalid pulses alternate.
- **Reset mid-load:** m1 load accepted; pull i_rstn low before the next edge. Required: no o_m1_rvalid pulse, and all response outputs are 0 during reset.
